bs_drvr_fifo: RTL and testbench
===============================

// Module: bs_drvr_fifo
// PURPOSE
//  Per-driver packet FIFO between a device port and the bus generator (bs_gnrtr).
//  - Device side writes packets with push/Din.
//  - Bus side sees pndng and a first-word-fall-through head on D_pop, and removes it with pop.
//  - Also reports occupancy, almost-full, and sticky overflow/underflow flags for debug.
//  - One instance per driver, DRVRS instances total.
// PARAMETERS
//  PCKG_SZ  128  packet width; [PCKG_SZ-1 -: 8]=target, [PCKG_SZ-9 -: 8]=source, [PCKG_SZ-17 -: 16]=ID
//  DEPTH    8    entries; power of 2, >= 2
//  AF_LVL   6    almost_full asserts when count >= AF_LVL (1..DEPTH)
// PORTS
//  clk          in   1                 rising-edge clock
//  reset        in   1                 asynchronous, active-high
//  push         in   1                 write strobe from device side
//  Din          in   PCKG_SZ           packet to write
//  pop          in   1                 bus has consumed head packet this cycle
//  D_pop        out  PCKG_SZ           head packet (FWFT); all-zero when empty
//  pndng        out  1                 FIFO non-empty
//  full         out  1                 count == DEPTH
//  almost_full  out  1                 count >= AF_LVL
//  count        out  $clog2(DEPTH)+1   stored packets, 0..DEPTH
//  overflow     out  1                 sticky: push dropped because full
//  underflow    out  1                 sticky: pop seen while empty
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert by the system):
//  - wr_ptr, rd_ptr, count = 0.
//  - pndng, full, almost_full, overflow, underflow = 0. D_pop = 0.
//  - Reset mid-operation discards all stored packets. Memory contents are don't-care.
//  Storage and pointers:
//  - DEPTH x PCKG_SZ array. Pointers are $clog2(DEPTH) bits and wrap naturally.
//  - count is a separate register, so there is no full/empty ambiguity at wrap.
//  Accept rules, evaluated on each clk rising edge:
//  - wr_en = push & (~full | pop). A pop in the same cycle frees the slot while full.
//  - rd_en = pop & pndng.
//  - wr_en writes Din at wr_ptr, then wr_ptr+1.
//  - rd_en advances rd_ptr by 1.
//  - count += wr_en - rd_en.
//  Simultaneous events:
//  - push & pop while empty: write accepted, pop ignored, underflow set, count becomes 1.
//  - push & pop while full: both accepted, count stays DEPTH, head advances.
//  - push & pop with 0 < count < DEPTH: both accepted, count unchanged.
//  Error flags:
//  - push & full & ~pop: packet dropped, overflow set. Cleared only by reset.
//  - pop & ~pndng: no state change, underflow set. Cleared only by reset.
//  Outputs:
//  - D_pop = mem[rd_ptr] when count != 0, else 0. Combinational from registered state.
//  - pndng = (count != 0); full = (count == DEPTH); almost_full = (count >= AF_LVL).
//  - All three are combinational from count; no other logic sits in the path.
//  Latency: a packet pushed at edge N is visible on D_pop/pndng after edge N, i.e. in cycle N+1.
//  Ordering: strict FIFO. The packet is never modified; the broadcast target 8'hFF passes through untouched.
// TESTING (PCKG_SZ=128, DEPTH=4, AF_LVL=3)
//  1. Reset, then push one packet {8'h01,8'h00,16'h0005,96'h0}.
//     -> next cycle: pndng=1, count=1, D_pop[127:96]=32'h0100_0005.
//     Pop it -> pndng=0, D_pop=0.
//  2. Push IDs 0..3 back-to-back.
//     -> almost_full=1 at count=3; full=1 at count=4.
//     5th push (ID 4) without pop -> dropped, overflow=1, count=4.
//     Four pops return IDs 0,1,2,3 in order.
//  3. Full FIFO, push ID 9 with pop in the same cycle.
//     -> count stays 4, overflow stays 0, head advances.
//     Drain order ends with ID 9.
//  4. Empty FIFO, push ID 7 with pop in the same cycle.
//     -> count=1, D_pop ID=7, underflow=1.
//  5. Wrap-around: 10 interleaved push/pop pairs with IDs 0..9 across the DEPTH=4 boundary.
//     -> popped IDs are 0..9 in order, count never exceeds 1.
//  6. Assert reset asynchronously (mid-cycle) with count=3.
//     -> pndng, count, flags, D_pop go to 0 immediately, with no clk edge needed.
//     After release, a push of ID 2 pops as ID 2.

Source files
------------

// File: rtl/bs_drvr_fifo.sv
// bs_drvr_fifo: per-driver packet FIFO between a device port and the bus generator.
// The device side writes packets with push/Din. The bus side sees a first-word-fall-through
// head on D_pop and removes it with pop. The block also reports occupancy, almost-full, and
// sticky overflow/underflow flags for debug.
module bs_drvr_fifo #(
    parameter int PCKG_SZ = 128,
    parameter int DEPTH   = 8,
    parameter int AF_LVL  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PCKG_SZ-1:0]         Din,
    input  logic                       pop,
    output logic [PCKG_SZ-1:0]         D_pop,
    output logic                       pndng,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);

    logic [PCKG_SZ-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               wr_en;
    logic               rd_en;

    // Occupancy flags depend only on count.
    always_comb begin
        pndng       = (count != '0);
        full        = (count == DEPTH_C);
        almost_full = (count >= AF_C);
    end

    // Accept rules: a pop in the same cycle frees the slot of a full FIFO.
    always_comb begin
        wr_en = push & (~full | pop);
        rd_en = pop & pndng;
    end

    // Head packet, forced to zero while empty so stale memory never appears.
    always_comb begin
        D_pop = '0;
        if (pndng) begin
            D_pop = mem[rd_ptr];
        end
    end

    // Packet storage. It has no reset because contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= Din;
        end
    end

    // Pointers, occupancy count, and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
            if (pop & ~pndng) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bs_drvr_fifo.sv
// Scoreboard bench for bs_drvr_fifo (PCKG_SZ=128, DEPTH=4, AF_LVL=3).
module tb_bs_drvr_fifo;

    logic         clk;
    logic         reset;
    logic         push;
    logic [127:0] Din;
    logic         pop;
    logic [127:0] D_pop;
    logic         pndng;
    logic         full;
    logic         almost_full;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];

    bs_drvr_fifo #(.PCKG_SZ(128), .DEPTH(4), .AF_LVL(3)) dut (
        .clk(clk), .reset(reset), .push(push), .Din(Din), .pop(pop),
        .D_pop(D_pop), .pndng(pndng), .full(full), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet with the given target and ID. The payload is derived from the ID so that every packet is distinct.
    function automatic logic [127:0] pkt(input logic [7:0] tgt, input int id);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ 32'(id);
        return {tgt, 8'h22, 16'(id), w, w, w};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: each accepted pop must present the next expected head packet.
    always @(negedge clk) begin
        if (pop && pndng && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", D_pop);
            end else begin
                check("pop_data", D_pop, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; Din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 128'(count), 128'd0);
        check("rst_flags", 128'({pndng, full, almost_full, overflow, underflow}), 128'd0);
        check("rst_dpop", D_pop, 128'd0);
        reset = 1'b0;
        tick();

        // 1: single packet
        push = 1'b1; Din = {8'h01, 8'h00, 16'h0005, 96'h0}; exp_q.push_back(Din);
        tick();
        push = 1'b0;
        check("t1_pndng", 128'(pndng), 128'd1);
        check("t1_count", 128'(count), 128'd1);
        check("t1_head", 128'(D_pop[127:96]), 128'h0100_0005);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("t1_empty_pndng", 128'(pndng), 128'd0);
        check("t1_empty_dpop", D_pop, 128'd0);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; Din = pkt(8'h03, i); exp_q.push_back(Din);
            tick();
            check("t2_count", 128'(count), 128'(i + 1));
            check("t2_af", 128'(almost_full), 128'(i + 1 >= 3));
            check("t2_full", 128'(full), 128'(i + 1 == 4));
        end
        check("t2_ovf_before", 128'(overflow), 128'd0);
        Din = pkt(8'h03, 4);
        tick();
        push = 1'b0;
        check("t2_ovf", 128'(overflow), 128'd1);
        check("t2_count_full", 128'(count), 128'd4);
        pop = 1'b1;
        repeat (4) tick();
        pop = 1'b0;
        check("t2_drained", 128'(count), 128'd0);
        check("t2_q_empty", 128'(exp_q.size()), 128'd0);

        reset = 1'b1; #2; reset = 1'b0;
        tick();

        // 3: push and pop while full, using the broadcast target
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; Din = pkt(8'hFF, i); exp_q.push_back(Din);
            tick();
        end
        pop = 1'b1; Din = pkt(8'hFF, 9); exp_q.push_back(Din);
        tick();
        push = 1'b0;
        check("t3_count", 128'(count), 128'd4);
        check("t3_ovf", 128'(overflow), 128'd0);
        check("t3_head", D_pop, pkt(8'hFF, 1));
        repeat (4) tick();
        pop = 1'b0;
        check("t3_q_empty", 128'(exp_q.size()), 128'd0);
        check("t3_count0", 128'(count), 128'd0);

        // 4: push and pop while empty
        check("t4_udf_before", 128'(underflow), 128'd0);
        push = 1'b1; pop = 1'b1; Din = pkt(8'h04, 7); exp_q.push_back(Din);
        tick();
        push = 1'b0; pop = 1'b0;
        check("t4_count", 128'(count), 128'd1);
        check("t4_head", D_pop, pkt(8'h04, 7));
        check("t4_udf", 128'(underflow), 128'd1);
        pop = 1'b1;
        tick();
        pop = 1'b0;

        // 5: wrap-around with overlapped push/pop
        push = 1'b1; Din = pkt(8'h05, 0); exp_q.push_back(Din);
        tick();
        for (int i = 1; i < 10; i++) begin
            pop = 1'b1; Din = pkt(8'h05, i); exp_q.push_back(Din);
            tick();
            check("t5_count", 128'(count), 128'd1);
        end
        push = 1'b0;
        tick();
        pop = 1'b0;
        check("t5_count0", 128'(count), 128'd0);
        check("t5_q_empty", 128'(exp_q.size()), 128'd0);

        // 6: asynchronous reset with count=3
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; Din = pkt(8'h06, i);
            tick();
        end
        push = 1'b0;
        check("t6_pre_count", 128'(count), 128'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_count", 128'(count), 128'd0);
        check("t6_flags", 128'({pndng, full, almost_full, overflow, underflow}), 128'd0);
        check("t6_dpop", D_pop, 128'd0);
        reset = 1'b0;
        tick();
        push = 1'b1; Din = pkt(8'h06, 2); exp_q.push_back(Din);
        tick();
        push = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        check("t6_q_empty", 128'(exp_q.size()), 128'd0);
        check("t6_count0", 128'(count), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
